// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate operations.
`ifndef MDUOP_SIZE
`define MDUOP_SIZE 4
`endif

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            operand1,
  input  logic [31:0]            operand2,
  input  logic [`MDUOP_SIZE-1:0] operation,
  input  logic                   start,
  output logic                   busy,
  output logic [31:0]            hi,
  output logic [31:0]            lo,
  output logic [31:0]            result
);

  localparam logic [`MDUOP_SIZE-1:0] OP_MULT  = 4'd1;
  localparam logic [`MDUOP_SIZE-1:0] OP_MULTU = 4'd2;
  localparam logic [`MDUOP_SIZE-1:0] OP_DIV   = 4'd3;
  localparam logic [`MDUOP_SIZE-1:0] OP_DIVU  = 4'd4;
  localparam logic [`MDUOP_SIZE-1:0] OP_MTHI  = 4'd5;
  localparam logic [`MDUOP_SIZE-1:0] OP_MTLO  = 4'd6;
  localparam logic [`MDUOP_SIZE-1:0] OP_MFHI  = 4'd7;
  localparam logic [`MDUOP_SIZE-1:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [`MDUOP_SIZE-1:0] OP_MADD  = 4'd9;
  localparam logic [`MDUOP_SIZE-1:0] OP_MADDU = 4'd10;
  localparam logic [`MDUOP_SIZE-1:0] OP_MSUB  = 4'd11;
  localparam logic [`MDUOP_SIZE-1:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, divu_den, quot_u, rem_u, quot_mag, rem_mag, quot_s, rem_s;
  logic        div_zero;

  // Signed product is formed from sign-extended operands; the low 64 bits of a
  // wide unsigned multiply are then the correct two's-complement result.
  always_comb begin
    prod_s   = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    prod_u   = {32'd0, operand1} * {32'd0, operand2};
    div_zero = (operand2 == 32'd0);
    divu_den = div_zero ? 32'd1 : operand2;
    quot_u   = operand1 / divu_den;
    rem_u    = operand1 % divu_den;
    abs_a    = operand1[31] ? (32'd0 - operand1) : operand1;
    abs_b    = operand2[31] ? (32'd0 - operand2) : (div_zero ? 32'd1 : operand2);
    quot_mag = abs_a / abs_b;
    rem_mag  = abs_a % abs_b;
    // Magnitude division handles 0x80000000 / -1 without overflow: it wraps to 0x80000000.
    quot_s   = (operand1[31] ^ operand2[31]) ? (32'd0 - quot_mag) : quot_mag;
    rem_s    = operand1[31] ? (32'd0 - rem_mag) : rem_mag;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s;
              cnt_d          = 32'(MULT_CYCLES);
              state_d        = RUN;
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u;
              cnt_d          = 32'(MULT_CYCLES);
              state_d        = RUN;
            end
            OP_DIV: begin
              {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {rem_s, quot_s};
              cnt_d          = 32'(DIV_CYCLES);
              state_d        = RUN;
            end
            OP_DIVU: begin
              {phi_d, plo_d} = div_zero ? {hi_q, lo_q} : {rem_u, quot_u};
              cnt_d          = 32'(DIV_CYCLES);
              state_d        = RUN;
            end
            OP_MTHI: hi_d = operand1;
            OP_MTLO: lo_d = operand1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              unique case (operation)
                OP_MADD:  {phi_d, plo_d} = {hi_q, lo_q} + prod_s;
                OP_MADDU: {phi_d, plo_d} = {hi_q, lo_q} + prod_u;
                OP_MSUB:  {phi_d, plo_d} = {hi_q, lo_q} - prod_s;
                default:  {phi_d, plo_d} = {hi_q, lo_q} - prod_u;
              endcase
              cnt_d   = 32'(MULT_CYCLES);
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == 32'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    result = 32'd0;
    if (operation == OP_MFHI)      result = hi_q;
    else if (operation == OP_MFLO) result = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: timing of busy, HI/LO results, reset abort,
// ignore-while-busy and the optional accumulate operations.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] operand1, operand2;
  logic [3:0]  operation;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .operand1  (operand1),
    .operand2  (operand2),
    .operation (operation),
    .start     (start),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .result    (result)
  );

  // Pulses start for one edge; returns at the falling edge right after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operation = op;
    operand1  = a;
    operand2  = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    operation = OP_NONE;
  endtask

  // Counts falling edges with busy high, bounded so a stuck busy cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s: hi/lo got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic expect_busy_len(input string name, input int exp_n);
    int n;
    count_busy(n);
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s: busy cycles got %0d expected %0d", name, n, exp_n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    expect_hilo("reset_hilo", 32'h0, 32'h0);
    operation = OP_MFHI;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 0", result);
    end
    operation = OP_NONE;
  endtask

  task automatic test_mult;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    expect_busy_len("mult_busy", 5);
    expect_hilo("mult_signed", 32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    expect_busy_len("multu_busy", 5);
    expect_hilo("multu", 32'h1, 32'hFFFFFFFE);
  endtask

  task automatic test_div;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    expect_busy_len("div_busy", 10);
    expect_hilo("div_signed", 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    expect_busy_len("divu_busy", 10);
    expect_hilo("divu", 32'h1, 32'h7FFFFFFC);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    expect_busy_len("div_ovf_busy", 10);
    expect_hilo("div_overflow", 32'h0, 32'h80000000);
    issue(OP_DIV, 32'd100, 32'hFFFFFFF9);
    expect_busy_len("div_negdiv_busy", 10);
    expect_hilo("div_neg_divisor", 32'h2, 32'hFFFFFFF2);
  endtask

  task automatic test_div_zero;
    issue(OP_MTHI, 32'h1234, 32'h0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_busy: got %b expected 0", busy);
    end
    issue(OP_MTLO, 32'h5678, 32'h0);
    expect_hilo("mthi_mtlo", 32'h1234, 32'h5678);
    issue(OP_DIVU, 32'd7, 32'd0);
    expect_busy_len("divzero_busy", 10);
    expect_hilo("divzero_keep", 32'h1234, 32'h5678);
    operation = OP_MFHI;
    #1;
    checks++;
    if (result !== 32'h1234) begin
      errors++;
      $display("FAIL mfhi_result: got %h expected 1234", result);
    end
    operation = OP_MFLO;
    #1;
    checks++;
    if (result !== 32'h5678) begin
      errors++;
      $display("FAIL mflo_result: got %h expected 5678", result);
    end
    operation = OP_NONE;
    #1;
    checks++;
    if (result !== 32'h0) begin
      errors++;
      $display("FAIL none_result: got %h expected 0", result);
    end
  endtask

  task automatic test_reset_abort;
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", busy);
    end
    expect_hilo("abort_cleared", 32'h0, 32'h0);
    repeat (15) @(negedge clk);
    expect_hilo("abort_no_commit", 32'h0, 32'h0);
  endtask

  task automatic test_ignore_busy;
    issue(OP_MULT, 32'd3, 32'd4);
    issue(OP_MTLO, 32'hAAAA, 32'h0);
    expect_hilo("busy_old_value", 32'h0, 32'h0);
    expect_busy_len("ignore_busy_rest", 3);
    expect_hilo("ignore_mtlo", 32'h0, 32'd12);
    issue(OP_MFHI, 32'h0, 32'h0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_mfhi_busy: got %b expected 0", busy);
    end
    expect_hilo("start_mfhi_nochange", 32'h0, 32'd12);
  endtask

  task automatic test_madd;
    issue(OP_MTHI, 32'h0, 32'h0);
    issue(OP_MTLO, 32'd10, 32'h0);
    issue(OP_MADD, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
    expect_busy_len("madd_busy", 5);
    expect_hilo("madd", 32'h0, 32'd22);
    issue(OP_MSUBU, 32'd5, 32'd5);
    expect_busy_len("msubu_busy", 5);
    expect_hilo("msubu", 32'hFFFFFFFF, 32'hFFFFFFFD);
`else
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL madd_disabled_busy: got %b expected 0", busy);
    end
    expect_hilo("madd_disabled", 32'h0, 32'd10);
    issue(OP_MSUBU, 32'd5, 32'd5);
    expect_hilo("msubu_disabled", 32'h0, 32'd10);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    operation = OP_NONE;
    operand1  = 32'h0;
    operand2  = 32'h0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_reset_abort;
    test_ignore_busy;
    test_madd;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
